// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use, jr/jalr, jumps, taken branches, mul hold.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [1:0] id_pcsrc,
   input  logic       ex_memread,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_wreg,
   input  logic       ex_is_mul,
   input  logic       ex_branch_taken,
   input  logic       mem_memread,
   input  logic [4:0] mem_wreg,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_write,
   output logic       id_ex_flush,
   output logic       ex_mem_bubble,
   output logic       mul_done
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0] perf_stall_cycles,
   output logic [15:0] perf_flushes
`endif
);

   typedef enum logic {RUN, MUL_WAIT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       mul_stall;
   logic       load_use;
   logic       jr_haz;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // $0 is hardwired, so a zero destination never creates a dependency
   always_comb begin
      mul_stall = ((state == RUN) && ex_is_mul) ||
                  ((state == MUL_WAIT) && (cnt > 4'd1));
      load_use  = ex_memread && (ex_wreg != 5'd0) &&
                  ((ex_wreg == id_rs) ||
                   (id_uses_rt && (ex_wreg == id_rt)));
      jr_haz    = (id_pcsrc == 2'b10) &&
                  ((ex_regwrite && (ex_wreg != 5'd0) &&
                    (ex_wreg == id_rs)) ||
                   (mem_memread && (mem_wreg != 5'd0) &&
                    (mem_wreg == id_rs)));
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mul_done = 1'b0;
      unique case (state)
         RUN: begin
            if (ex_is_mul) begin
               state_nx = MUL_WAIT;
               cnt_nx   = CNT_INIT;
            end
         end
         MUL_WAIT: begin
            if (cnt > 4'd1) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               state_nx = RUN;
               cnt_nx   = 4'd0;
               mul_done = !reset;
            end
         end
         default: begin
            state_nx = RUN;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   always_comb begin
      pc_write      = 1'b1;
      pc_sel        = 2'b00;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      if (reset) begin
         pc_write = 1'b1;
      end else if (mul_stall) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         pc_sel      = 2'b11;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use || jr_haz) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_pcsrc != 2'b00) begin
         pc_sel      = id_pcsrc;
         if_id_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= 16'd0;
         perf_flushes      <= 16'd0;
      end else begin
         if (!pc_write && (perf_stall_cycles != 16'hFFFF))
            perf_stall_cycles <= perf_stall_cycles + 16'd1;
         if (if_id_flush && (perf_flushes != 16'hFFFF))
            perf_flushes <= perf_flushes + 16'd1;
      end
   end
`endif

endmodule
